el2_ahbl_sram_slave: RTL and testbench
======================================

// Module: el2_ahbl_sram_slave
// PURPOSE
//  AHB-Lite slave (responder) with 64-bit data and internal word-organised memory; the far end of the
//  single AHB-Lite master port driven by the EL2 wrapper's IFU/LSU master mux. Sits behind the system
//  decoder and serves instruction fetches and LSU loads/stores. Supports programmable wait states,
//  byte-lane writes and two-cycle ERROR responses.
// PARAMETERS
//  DEPTH   1024  number of 64-bit memory words (power of two, >=2)
//  WS      0     wait states inserted per accepted data phase (0..15)
//  WIN_AW  20    width of the byte-address window decoded upstream; must satisfy WIN_AW >= clog2(DEPTH)+3
// PORTS
//  HCLK       in   1   system clock
//  HRESETn    in   1   synchronous reset, active low
//  HSEL       in   1   slave select from decoder
//  HADDR      in   32  transfer address
//  HTRANS     in   2   IDLE=00, BUSY=01, NONSEQ=10, SEQ=11
//  HSIZE      in   3   0=byte, 1=half, 2=word, 3=dword
//  HWRITE     in   1   1=write
//  HWDATA     in   64  write data (data phase)
//  HREADY     in   1   bus ready (from interconnect)
//  HREADYOUT  out  1   slave ready
//  HRDATA     out  64  read data
//  HRESP      out  1   0=OKAY, 1=ERROR
// BEHAVIOUR
//  - One clock (HCLK). Reset is synchronous and active-low on HRESETn. Reset values: HREADYOUT=1,
//    HRESP=0, HRDATA=0, FSM=IDLE, wait counter=0. Memory contents are not reset.
//  - Accept: an address phase is accepted on a rising edge where HSEL & HTRANS[1] & HREADY.
//    On accept, HADDR, HSIZE and HWRITE are registered. IDLE/BUSY or unselected cycles get zero-wait OKAY.
//  - Error check at accept. The transfer is an error if any of these holds:
//    HSIZE>3; HADDR misaligned to HSIZE; word index HADDR[WIN_AW-1:3] >= DEPTH.
//  - FSM states: IDLE, DATA, ERR1, ERR2.
//    IDLE: HREADYOUT=1, HRESP=0. Go to DATA on a good accept, ERR1 on a bad accept.
//    DATA: wait counter loads WS on entry. While count!=0: HREADYOUT=0, decrement.
//      At count==0 (final cycle): HREADYOUT=1, HRESP=0. Next state is DATA, ERR1 or IDLE,
//      chosen by a same-cycle accept check (back-to-back pipelining, no bubble).
//    ERR1: HREADYOUT=0, HRESP=1; always go to ERR2. Address phase is ignored here (HREADY low).
//    ERR2: HREADYOUT=1, HRESP=1; accept is evaluated as in IDLE.
//  - Latency: read data valid N=WS+1 cycles after the accept edge. With WS=0 the data phase is one cycle.
//  - Write: commits at the edge ending the final DATA cycle, using HWDATA of that cycle.
//    Lane mask = ((1<<(1<<size_q))-1) << addr_q[2:0], little-endian. Unmasked bytes are unchanged.
//    Erroring writes never modify memory.
//  - Read: HRDATA = mem[addr_q index] (full 64 bits, all lanes) during the final DATA cycle;
//    HRDATA=0 in all other cycles. A read whose data phase follows a write data phase returns the
//    newly written bytes; the write has committed before the read's final cycle.
//  - HREADY low with no active data phase (another slave stalling): hold state, accept nothing.
//  - Reset asserted mid-transfer: the pending phase is discarded, no write commits, and outputs take
//    reset values on the next edge.
//  - Wait counter width is 4 bits; WS>15 is illegal (assert in simulation).
// TESTING
//  - WS=0: write dword 0x1122334455667788 @0x0, then read @0x0 back-to-back ->
//    HRDATA=0x1122334455667788 one cycle after the read accept, HREADYOUT never low.
//  - Byte write 0xAA @0x5 over 0xFFFF...FF -> read @0x0 = 0xFFFFAAFFFFFFFFFF. Half write @0x2 of 0xBEEF
//    -> bytes 2..3 updated only.
//  - WS=3: NONSEQ read -> HREADYOUT low for exactly 3 cycles, then high with data. SEQ pipelined reads
//    each take 4 cycles with no idle gap.
//  - Misaligned word @0x2 or index=DEPTH -> HRESP=1 with HREADYOUT=0 then 1 (2 cycles); memory unchanged;
//    next good read returns OKAY.
//  - IDLE/BUSY or HSEL=0 with HTRANS=NONSEQ -> HREADYOUT=1, HRESP=0, no memory access.
//  - HRESETn low during a WS=3 write wait -> next cycle HREADYOUT=1, HRESP=0; memory word unchanged.

Source files
------------

// File: rtl/el2_ahbl_sram_slave.sv
// AHB-Lite 64-bit SRAM responder with programmable wait states, byte-lane writes
// and two-cycle ERROR responses.
module el2_ahbl_sram_slave #(
    parameter int unsigned DEPTH  = 1024,
    parameter int unsigned WS     = 0,
    parameter int unsigned WIN_AW = 20
) (
    input  logic        HCLK,
    input  logic        HRESETn,
    input  logic        HSEL,
    input  logic [31:0] HADDR,
    input  logic [1:0]  HTRANS,
    input  logic [2:0]  HSIZE,
    input  logic        HWRITE,
    input  logic [63:0] HWDATA,
    input  logic        HREADY,
    output logic        HREADYOUT,
    output logic [63:0] HRDATA,
    output logic        HRESP
);
    localparam int unsigned IdxW  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [3:0]  WsCnt = 4'(WS);

    typedef enum logic [1:0] {StIdle, StData, StErr1, StErr2} state_e;

    state_e          state_q, state_d;
    logic [3:0]      cnt_q, cnt_d;
    logic            hreadyout_q, hreadyout_d;
    logic            hresp_q, hresp_d;
    logic [IdxW-1:0] idx_q;
    logic [2:0]      off_q;
    logic [1:0]      size_q;
    logic            write_q;
    logic [63:0]     mem_q [DEPTH];

    logic              accept, can_accept, final_data;
    logic              misalign, oob, bad;
    logic [WIN_AW-4:0] win_idx;
    logic [7:0]        lane_base, lane_mask;
    logic              unused_in;

    assign unused_in = ^{HADDR, HTRANS[0]};
    assign win_idx   = HADDR[WIN_AW-1:3];
    assign oob       = 32'(win_idx) >= DEPTH;
    assign bad       = HSIZE[2] | misalign | oob;

    always_comb begin
        case (HSIZE)
            3'd1:    misalign = HADDR[0];
            3'd2:    misalign = |HADDR[1:0];
            3'd3:    misalign = |HADDR[2:0];
            default: misalign = 1'b0;
        endcase
    end

    always_comb begin
        case (size_q)
            2'd0:    lane_base = 8'h01;
            2'd1:    lane_base = 8'h03;
            2'd2:    lane_base = 8'h0F;
            default: lane_base = 8'hFF;
        endcase
        lane_mask = lane_base << off_q;
    end

    always_comb begin
        final_data = (state_q == StData) && (cnt_q == 4'd0);
        can_accept = (state_q == StIdle) || (state_q == StErr2) || final_data;
        accept     = HSEL && HTRANS[1] && HREADY;
        state_d    = state_q;
        cnt_d      = cnt_q;
        unique case (state_q)
            StIdle: state_d = StIdle;
            StData: begin
                if (cnt_q != 4'd0) cnt_d = cnt_q - 4'd1;
                else               state_d = StIdle;
            end
            StErr1: state_d = StErr2;
            StErr2: state_d = StIdle;
            default: state_d = StIdle;
        endcase
        // Final data cycle and ERR2 double as address phases: pipelined accept, no bubble.
        if (can_accept && accept) begin
            state_d = bad ? StErr1 : StData;
            cnt_d   = bad ? 4'd0 : WsCnt;
        end
        hreadyout_d = (state_d != StErr1) && !((state_d == StData) && (cnt_d != 4'd0));
        hresp_d     = (state_d == StErr1) || (state_d == StErr2);
    end

    always_ff @(posedge HCLK) begin
        if (!HRESETn) begin
            state_q     <= StIdle;
            cnt_q       <= 4'd0;
            hreadyout_q <= 1'b1;
            hresp_q     <= 1'b0;
            idx_q       <= '0;
            off_q       <= 3'd0;
            size_q      <= 2'd0;
            write_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            hreadyout_q <= hreadyout_d;
            hresp_q     <= hresp_d;
            if (can_accept && accept) begin
                idx_q   <= HADDR[IdxW+2:3];
                off_q   <= HADDR[2:0];
                size_q  <= HSIZE[1:0];
                write_q <= HWRITE;
            end
        end
    end

    // Memory is not reset; a reset edge suppresses any pending commit.
    always_ff @(posedge HCLK) begin
        if (HRESETn && final_data && write_q) begin
            for (int b = 0; b < 8; b++) begin
                if (lane_mask[b]) mem_q[idx_q][8*b +: 8] <= HWDATA[8*b +: 8];
            end
        end
    end

    always_ff @(posedge HCLK) begin
        ws_range_a: assert (WS <= 32'd15);
    end

    assign HREADYOUT = hreadyout_q;
    assign HRESP     = hresp_q;
    assign HRDATA    = (final_data && !write_q) ? mem_q[idx_q] : 64'h0;
endmodule

// File: tb/tb_el2_ahbl_sram_slave.sv
// Bench for el2_ahbl_sram_slave: WS=0 and WS=3 instances driven by a pipelined
// AHB-Lite master; expected responses queued at accept and compared at completion.
module tb_el2_ahbl_sram_slave;
    typedef struct {
        logic        sel;
        logic [1:0]  trans;
        logic        wr;
        logic [31:0] addr;
        logic [2:0]  size;
        logic [63:0] wdata;
        logic        exp_err;
        logic [63:0] exp_rdata;
    } vec_t;

    typedef struct {
        int          idx;
        logic        err;
        logic [63:0] rdata;
        int          waits;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        sel_b, inst, stall;
    logic [31:0] haddr;
    logic [1:0]  htrans;
    logic [2:0]  hsize;
    logic        hwrite;
    logic [63:0] hwdata;
    logic        ro0, ro3, resp0, resp3;
    logic [63:0] rd0, rd3;
    logic        ro, resp, hready;
    logic [63:0] rdata;

    int   nvec = 0;
    int   nmis = 0;
    int   cyc;
    vec_t vecs [29];
    exp_t sb [$];

    always #5 clk = ~clk;

    assign ro     = inst ? ro3 : ro0;
    assign resp   = inst ? resp3 : resp0;
    assign rdata  = inst ? rd3 : rd0;
    assign hready = ro & ~stall;

    el2_ahbl_sram_slave #(.DEPTH(1024), .WS(0), .WIN_AW(20)) u_ws0 (
        .HCLK(clk), .HRESETn(rst_n), .HSEL(sel_b & ~inst), .HADDR(haddr), .HTRANS(htrans),
        .HSIZE(hsize), .HWRITE(hwrite), .HWDATA(hwdata), .HREADY(hready),
        .HREADYOUT(ro0), .HRDATA(rd0), .HRESP(resp0)
    );

    el2_ahbl_sram_slave #(.DEPTH(1024), .WS(3), .WIN_AW(20)) u_ws3 (
        .HCLK(clk), .HRESETn(rst_n), .HSEL(sel_b & inst), .HADDR(haddr), .HTRANS(htrans),
        .HSIZE(hsize), .HWRITE(hwrite), .HWDATA(hwdata), .HREADY(hready),
        .HREADYOUT(ro3), .HRDATA(rd3), .HRESP(resp3)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        nvec++;
        if (act !== exp) begin
            nmis++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic sv(input int i, input logic sel, input logic [1:0] trans, input logic wr,
                      input logic [31:0] addr, input logic [2:0] size, input logic [63:0] wdata,
                      input logic err, input logic [63:0] rd);
        vecs[i] = '{sel, trans, wr, addr, size, wdata, err, rd};
    endtask

    task automatic drive_idle();
        sel_b = 1'b0; htrans = 2'b00; hwrite = 1'b0; haddr = 32'h0; hsize = 3'd0;
    endtask

    task automatic drive_vec(input int i);
        sel_b = vecs[i].sel; htrans = vecs[i].trans; hwrite = vecs[i].wr;
        haddr = vecs[i].addr; hsize = vecs[i].size;
    endtask

    // Each cycle: drive data/address phase at negedge, retire the data phase when HREADYOUT is high.
    task automatic run_seq(input int lo, input int hi, output int cycles);
        int   ap = lo;
        int   waits = 0;
        int   guard = 0;
        int   ws_cur = inst ? 3 : 0;
        exp_t e;
        cycles = 0;
        while ((ap <= hi || sb.size() > 0) && guard < 400) begin
            @(negedge clk);
            guard++;
            hwdata = (sb.size() > 0) ? vecs[sb[0].idx].wdata : 64'h0;
            if (ap <= hi) drive_vec(ap);
            else          drive_idle();
            if (sb.size() > 0) begin
                cycles++;
                if (!ro) waits++;
                else begin
                    e = sb.pop_front();
                    chk($sformatf("v%0d hresp", e.idx), 64'(resp), 64'(e.err));
                    chk($sformatf("v%0d hrdata", e.idx), rdata, e.rdata);
                    chk($sformatf("v%0d waits", e.idx), 64'(waits), 64'(e.waits));
                    waits = 0;
                end
            end
            if (hready && ap <= hi) begin
                e.idx   = ap;
                e.err   = vecs[ap].exp_err;
                e.rdata = vecs[ap].exp_rdata;
                e.waits = (!vecs[ap].sel || !vecs[ap].trans[1]) ? 0 :
                          vecs[ap].exp_err ? 1 : ws_cur;
                sb.push_back(e);
                ap++;
            end
        end
        if (guard >= 400) begin
            nvec++;
            nmis++;
            $display("FAIL seq %0d-%0d timeout: got no completion, expected completion", lo, hi);
            sb.delete();
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected finish");
        $fatal(1);
    end

    initial begin
        // WS=0 instance
        sv(0,  1, 2'b10, 1, 32'h0000, 3'd3, 64'h1122334455667788, 0, 64'h0);
        sv(1,  1, 2'b10, 0, 32'h0000, 3'd3, 64'h0, 0, 64'h1122334455667788);
        sv(2,  1, 2'b10, 1, 32'h0000, 3'd3, 64'hFFFFFFFFFFFFFFFF, 0, 64'h0);
        sv(3,  1, 2'b10, 1, 32'h0005, 3'd0, 64'h1234AA56789ABCDE, 0, 64'h0);
        sv(4,  1, 2'b10, 0, 32'h0000, 3'd3, 64'h0, 0, 64'hFFFFAAFFFFFFFFFF);
        sv(5,  1, 2'b10, 1, 32'h0002, 3'd1, 64'h55555555BEEF5555, 0, 64'h0);
        sv(6,  1, 2'b10, 0, 32'h0000, 3'd3, 64'h0, 0, 64'hFFFFAAFFBEEFFFFF);
        sv(7,  1, 2'b11, 0, 32'h0004, 3'd2, 64'h0, 0, 64'hFFFFAAFFBEEFFFFF);
        sv(8,  1, 2'b10, 1, 32'h0002, 3'd2, 64'h0, 1, 64'h0);
        sv(9,  1, 2'b10, 0, 32'h0000, 3'd3, 64'h0, 0, 64'hFFFFAAFFBEEFFFFF);
        sv(10, 1, 2'b10, 1, 32'h2000, 3'd3, 64'h0, 1, 64'h0);
        sv(11, 1, 2'b10, 1, 32'h1FF8, 3'd3, 64'hCAFEF00DDEADBEEF, 0, 64'h0);
        sv(12, 1, 2'b10, 0, 32'h1FF8, 3'd3, 64'h0, 0, 64'hCAFEF00DDEADBEEF);
        sv(13, 1, 2'b00, 1, 32'h0000, 3'd3, 64'h0, 0, 64'h0);
        sv(14, 1, 2'b01, 1, 32'h0000, 3'd3, 64'h0, 0, 64'h0);
        sv(15, 0, 2'b10, 1, 32'h0000, 3'd3, 64'h0, 0, 64'h0);
        sv(16, 1, 2'b10, 0, 32'h0000, 3'd3, 64'h0, 0, 64'hFFFFAAFFBEEFFFFF);
        sv(17, 1, 2'b10, 0, 32'h0000, 3'd4, 64'h0, 1, 64'h0);
        sv(18, 1, 2'b10, 0, 32'h0004, 3'd3, 64'h0, 1, 64'h0);
        sv(19, 1, 2'b11, 0, 32'h0005, 3'd0, 64'h0, 0, 64'hFFFFAAFFBEEFFFFF);
        // WS=3 instance
        sv(20, 1, 2'b10, 1, 32'h0010, 3'd3, 64'h0123456789ABCDEF, 0, 64'h0);
        sv(21, 1, 2'b11, 1, 32'h0018, 3'd3, 64'hFEDCBA9876543210, 0, 64'h0);
        sv(22, 1, 2'b10, 0, 32'h0010, 3'd3, 64'h0, 0, 64'h0123456789ABCDEF);
        sv(23, 1, 2'b11, 0, 32'h0018, 3'd3, 64'h0, 0, 64'hFEDCBA9876543210);
        sv(24, 1, 2'b11, 0, 32'h0010, 3'd3, 64'h0, 0, 64'h0123456789ABCDEF);
        sv(25, 1, 2'b10, 0, 32'h0011, 3'd1, 64'h0, 1, 64'h0);
        sv(26, 1, 2'b10, 0, 32'h0018, 3'd3, 64'h0, 0, 64'hFEDCBA9876543210);
        // Read-backs after the stall and reset sequences
        sv(27, 1, 2'b10, 0, 32'h0000, 3'd3, 64'h0, 0, 64'hFFFFAAFFBEEFFFFF);
        sv(28, 1, 2'b10, 0, 32'h0010, 3'd3, 64'h0, 0, 64'h0123456789ABCDEF);

        inst = 1'b0; stall = 1'b0; hwdata = 64'h0; rst_n = 1'b0;
        drive_idle();
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        chk("rst ro0", 64'(ro0), 64'd1);
        chk("rst resp0", 64'(resp0), 64'd0);
        chk("rst rd0", rd0, 64'h0);
        chk("rst ro3", 64'(ro3), 64'd1);
        chk("rst resp3", 64'(resp3), 64'd0);
        chk("rst rd3", rd3, 64'h0);

        run_seq(0, 19, cyc);
        chk("ws0 seq cycles", 64'(cyc), 64'd24);

        // Another slave holding HREADY low: nothing may be accepted.
        @(negedge clk);
        stall = 1'b1;
        sel_b = 1'b1; htrans = 2'b10; hwrite = 1'b1; haddr = 32'h0; hsize = 3'd3;
        hwdata = 64'h0;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk($sformatf("stall ro %0d", k), 64'(ro0), 64'd1);
        end
        drive_idle();
        stall = 1'b0;
        run_seq(27, 27, cyc);

        inst = 1'b1;
        run_seq(20, 24, cyc);
        chk("ws3 pipelined cycles", 64'(cyc), 64'd20);
        run_seq(25, 26, cyc);
        chk("ws3 err+read cycles", 64'(cyc), 64'd6);

        // Reset in the middle of a WS=3 write wait.
        @(negedge clk);
        sel_b = 1'b1; htrans = 2'b10; hwrite = 1'b1; haddr = 32'h10; hsize = 3'd3;
        @(negedge clk);
        chk("rstmid wait ro", 64'(ro3), 64'd0);
        drive_idle();
        hwdata = 64'hDEADDEADDEADDEAD;
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        chk("rstmid ro", 64'(ro3), 64'd1);
        chk("rstmid resp", 64'(resp3), 64'd0);
        chk("rstmid rd", rd3, 64'h0);
        hwdata = 64'h0;
        run_seq(28, 28, cyc);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
        $finish;
    end
endmodule
